// File: rtl/sound_frame_sequencer.sv
// Frame sequencer for the four-channel sound unit.
// Divides clk to the 512 Hz frame step, issues the length/sweep/envelope ticks,
// and owns the per-channel length counters, trigger hold-off and active status.
module sound_frame_sequencer #(
    parameter int CLK_HZ    = 4194304,
    parameter int SEQ_HZ    = 512,
    parameter int INIT_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       master_en,
    input  logic [3:0] trig,
    input  logic [3:0] len_load,
    input  logic [7:0] len_data,
    input  logic [3:0] len_en,
    input  logic [3:0] dac_en,
    output logic       len_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic [2:0] step,
    output logic [3:0] ch_run,
    output logic [3:0] ch_active
);

    localparam int DIV   = CLK_HZ / SEQ_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [7:0]       HOLD_INIT = 8'(INIT_HOLD);

    logic [DIV_W-1:0] div;
    logic [2:0]       next_step;

    // Per-channel length counters and initialize hold-off counters.
    logic [8:0] cnt      [4];
    logic [7:0] hold     [4];
    logic [8:0] load_val [4];
    logic [8:0] max_len  [4];
    logic [3:0] dec;
    logic [3:0] expire;

    assign next_step = step + 3'd1;

    // Clock divider and frame step; ticks are decoded from the step being entered
    // so each one is high for exactly the cycle following the step change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div        <= '0;
            step       <= 3'd7;
            len_tick   <= 1'b0;
            sweep_tick <= 1'b0;
            env_tick   <= 1'b0;
        end else if (!master_en) begin
            div        <= '0;
            step       <= 3'd7;
            len_tick   <= 1'b0;
            sweep_tick <= 1'b0;
            env_tick   <= 1'b0;
        end else if (div == DIV_LAST) begin
            div        <= '0;
            step       <= next_step;
            len_tick   <= ~next_step[0];
            sweep_tick <= (next_step[1:0] == 2'b10);
            env_tick   <= (next_step == 3'd7);
        end else begin
            div        <= div + 1'b1;
            len_tick   <= 1'b0;
            sweep_tick <= 1'b0;
            env_tick   <= 1'b0;
        end
    end

    // Load values, reload maxima and decrement/expiry qualifiers per channel;
    // channel 3 (index 2) has the full 8-bit length, the others use 6 bits.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            load_val[i] = 9'd0;
            max_len[i]  = 9'd0;
            dec[i]      = 1'b0;
            expire[i]   = 1'b0;
            if (i == 2) begin
                load_val[i] = 9'd256 - {1'b0, len_data};
                max_len[i]  = 9'd256;
            end else begin
                load_val[i] = 9'd64 - {3'b000, len_data[5:0]};
                max_len[i]  = 9'd64;
            end
            dec[i]    = len_tick && len_en[i] && (cnt[i] != 9'd0)
                        && !trig[i] && !len_load[i];
            expire[i] = dec[i] && (cnt[i] == 9'd1);
        end
    end

    // Length counters: a register write beats a trigger reload, which beats a tick decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 9'd0;
            end
        end else if (!master_en) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 9'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (len_load[i]) begin
                    cnt[i] <= load_val[i];
                end else if (trig[i] && (cnt[i] == 9'd0)) begin
                    cnt[i] <= max_len[i];
                end else if (dec[i]) begin
                    cnt[i] <= cnt[i] - 9'd1;
                end
            end
        end
    end

    // Channel status and initialize sequencing: a powered-down DAC always wins,
    // a trigger starts (or restarts) the hold-off, length expiry shuts the channel,
    // otherwise the hold-off counts down and releases ch_run as it reaches zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                hold[i] <= 8'd0;
            end
            ch_run    <= 4'd0;
            ch_active <= 4'd0;
        end else if (!master_en) begin
            for (int i = 0; i < 4; i++) begin
                hold[i] <= 8'd0;
            end
            ch_run    <= 4'd0;
            ch_active <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!dac_en[i]) begin
                    ch_active[i] <= 1'b0;
                    ch_run[i]    <= 1'b0;
                    hold[i]      <= 8'd0;
                end else if (trig[i]) begin
                    ch_active[i] <= 1'b1;
                    ch_run[i]    <= 1'b0;
                    hold[i]      <= HOLD_INIT;
                end else if (expire[i]) begin
                    ch_active[i] <= 1'b0;
                    ch_run[i]    <= 1'b0;
                    hold[i]      <= 8'd0;
                end else if (hold[i] != 8'd0) begin
                    hold[i] <= hold[i] - 8'd1;
                    if (hold[i] == 8'd1) begin
                        ch_run[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Directed bench for sound_frame_sequencer with DIV=8 and INIT_HOLD=4.
module tb_sound_frame_sequencer;

    localparam int CLK_HZ    = 4096;
    localparam int SEQ_HZ    = 512;
    localparam int INIT_HOLD = 4;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       master_en = 1'b0;
    logic [3:0] trig      = 4'd0;
    logic [3:0] len_load  = 4'd0;
    logic [7:0] len_data  = 8'd0;
    logic [3:0] len_en    = 4'd0;
    logic [3:0] dac_en    = 4'hF;
    logic       len_tick;
    logic       sweep_tick;
    logic       env_tick;
    logic [2:0] step;
    logic [3:0] ch_run;
    logic [3:0] ch_active;

    int total = 0;
    int bad   = 0;
    int decs;
    int cyc;
    int exp_step;
    logic prev_tick;

    sound_frame_sequencer #(
        .CLK_HZ   (CLK_HZ),
        .SEQ_HZ   (SEQ_HZ),
        .INIT_HOLD(INIT_HOLD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .master_en (master_en),
        .trig      (trig),
        .len_load  (len_load),
        .len_data  (len_data),
        .len_en    (len_en),
        .dac_en    (dac_en),
        .len_tick  (len_tick),
        .sweep_tick(sweep_tick),
        .env_tick  (env_tick),
        .step      (step),
        .ch_run    (ch_run),
        .ch_active (ch_active)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic advance(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until len_tick is visible, bounded to a few frame steps.
    task automatic wait_len_tick(input string tag);
        int i;
        i = 0;
        while (len_tick !== 1'b1 && i < 40) begin
            advance(1);
            i++;
        end
        check_output(tag, len_tick, 1);
    endtask

    initial begin
        // Reset state
        advance(2);
        check_output("rst step", step, 7);
        check_output("rst len_tick", len_tick, 0);
        check_output("rst sweep_tick", sweep_tick, 0);
        check_output("rst env_tick", env_tick, 0);
        check_output("rst ch_run", ch_run, 0);
        check_output("rst ch_active", ch_active, 0);
        reset_n = 1'b1;
        advance(2);
        check_output("disabled step", step, 7);

        // 1. Cadence over 64 cycles from enable
        master_en = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            advance(1);
            exp_step = (7 + k / 8) % 8;
            check_output("c1 step", step, exp_step);
            check_output("c1 len_tick", len_tick,
                         ((k % 8 == 0) && (exp_step % 2 == 0)) ? 1 : 0);
            check_output("c1 sweep_tick", sweep_tick,
                         ((k % 8 == 0) && (exp_step == 2 || exp_step == 6)) ? 1 : 0);
            check_output("c1 env_tick", env_tick,
                         ((k % 8 == 0) && (exp_step == 7)) ? 1 : 0);
        end

        // 2. Length expiry on ch1 with cnt=2
        len_data = 8'd62;
        len_load = 4'b0001;
        len_en   = 4'b0001;
        advance(1);
        len_load = 4'd0;
        trig     = 4'b0001;
        advance(1);
        trig = 4'd0;
        check_output("t2 active", ch_active[0], 1);
        check_output("t2 run low", ch_run[0], 0);
        advance(3);
        check_output("t2 run still low", ch_run[0], 0);
        advance(1);
        check_output("t2 run high", ch_run[0], 1);
        wait_len_tick("t2 tick1");
        advance(1);
        check_output("t2 active after tick1", ch_active[0], 1);
        wait_len_tick("t2 tick2");
        advance(1);
        check_output("t2 expired", ch_active[0], 0);
        check_output("t2 run dropped", ch_run[0], 0);

        // 3. Trigger ch3 with zero length: full 256 reload
        trig   = 4'b0100;
        len_en = 4'b0101;
        advance(1);
        trig = 4'd0;
        check_output("t3 active", ch_active[2], 1);
        check_output("t3 run low", ch_run[2], 0);
        decs      = 0;
        cyc       = 0;
        prev_tick = len_tick;
        while (ch_active[2] && cyc < 5000) begin
            advance(1);
            cyc++;
            if (prev_tick) decs++;
            if (cyc == 3) check_output("t3 run low at 3", ch_run[2], 0);
            if (cyc == 4) check_output("t3 run high at 4", ch_run[2], 1);
            prev_tick = len_tick;
        end
        check_output("t3 decrements", decs, 256);
        check_output("t3 expired", ch_active[2], 0);
        check_output("t3 run dropped", ch_run[2], 0);

        // 4a. Trigger ch2 in a len_tick cycle suppresses the decrement
        len_data = 8'd63;
        len_load = 4'b0010;
        len_en   = 4'b0111;
        advance(1);
        len_load = 4'd0;
        trig     = 4'b0010;
        advance(1);
        trig = 4'd0;
        check_output("t4 ch2 active", ch_active[1], 1);
        wait_len_tick("t4 tick a");
        trig = 4'b0010;
        advance(1);
        trig = 4'd0;
        check_output("t4 collide no dec", ch_active[1], 1);
        wait_len_tick("t4 tick b");
        advance(1);
        check_output("t4 ch2 expired", ch_active[1], 0);

        // 4b. len_load and trig together on ch1: loaded cnt=1 wins over reload
        len_data = 8'd63;
        len_load = 4'b0001;
        trig     = 4'b0001;
        advance(1);
        len_load = 4'd0;
        trig     = 4'd0;
        check_output("t4 ch1 active", ch_active[0], 1);
        wait_len_tick("t4 tick c");
        advance(1);
        check_output("t4 load wins", ch_active[0], 0);

        // 5. DAC off
        dac_en = 4'b0111;
        trig   = 4'b1000;
        advance(1);
        trig = 4'd0;
        check_output("t5 ch4 inactive", ch_active[3], 0);
        check_output("t5 ch4 run", ch_run[3], 0);
        trig = 4'b0001;
        advance(1);
        trig = 4'd0;
        advance(5);
        check_output("t5 ch1 active", ch_active[0], 1);
        check_output("t5 ch1 run", ch_run[0], 1);
        dac_en = 4'b0110;
        advance(1);
        check_output("t5 dac drop active", ch_active[0], 0);
        check_output("t5 dac drop run", ch_run[0], 0);
        dac_en = 4'hF;
        advance(2);
        check_output("t5 stays inactive", ch_active[0], 0);

        // Retrigger during hold restarts the hold-off (ch4)
        trig = 4'b1000;
        advance(1);
        trig = 4'd0;
        advance(2);
        trig = 4'b1000;
        advance(1);
        trig = 4'd0;
        check_output("rt run low", ch_run[3], 0);
        advance(3);
        check_output("rt run low at 3", ch_run[3], 0);
        advance(1);
        check_output("rt run high at 4", ch_run[3], 1);
        check_output("rt active", ch_active[3], 1);

        // 6a. master_en low mid-hold
        trig = 4'b0010;
        advance(1);
        trig = 4'd0;
        advance(1);
        master_en = 1'b0;
        trig      = 4'b0001;
        advance(1);
        trig = 4'd0;
        check_output("t6 clr run", ch_run, 0);
        check_output("t6 clr active", ch_active, 0);
        check_output("t6 clr step", step, 7);
        check_output("t6 clr len_tick", len_tick, 0);
        advance(2);
        check_output("t6 trig ignored", ch_active, 0);
        master_en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            advance(1);
            check_output("t6 resume len_tick", len_tick, (c == 8) ? 1 : 0);
            check_output("t6 resume step", step, (c == 8) ? 0 : 7);
        end

        // 6b. Async reset mid-count
        trig = 4'b0100;
        advance(1);
        trig = 4'd0;
        advance(5);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("t6 async run", ch_run, 0);
        check_output("t6 async active", ch_active, 0);
        check_output("t6 async step", step, 7);
        check_output("t6 async ticks", {len_tick, sweep_tick, env_tick}, 0);
        advance(2);
        reset_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            advance(1);
            check_output("t6 rst resume len_tick", len_tick, (c == 8) ? 1 : 0);
            check_output("t6 rst resume step", step, (c == 8) ? 0 : 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
